alu_ctrl_stage: RTL and testbench

ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

---
 rtl/alu_ctrl_stage.sv | 182 ++++++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage
//   Decodes {alu_op, funct3, funct7_5} into a 4-bit ALU select code and
//   registers the result in a two-entry skid buffer (main + skid), so that
//   in_ready is a pure register output with no path from out_ready.
//
//   Decode table:
//      00           -> 0010 (add)
//      01           -> 0110 (sub)
//      10 / 000     -> 0010 when funct7_5=0, 0110 when funct7_5=1
//      10 / 111     -> 0000 (and)
//      10 / 110     -> 0001 (or)
//      anything else -> 1111 with illegal=1
//
//   Optional feature (macro ALU_CTRL_ILLEGAL_CNT_EN): an 8-bit saturating
//   count of accepted illegal entries on port illegal_cnt. Without the macro
//   the port and the counter do not exist.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   flush        discard both buffered entries on the next edge
//   in_valid     upstream entry present
//   in_ready     stage can accept an entry (= skid empty)
//   alu_op       instruction class
//   funct3       instruction funct3
//   funct7_5     instruction bit 30
//   out_valid    sel/illegal valid toward the ALU
//   out_ready    ALU consumes the current entry
//   sel          ALU select code
//   illegal      current entry decoded as unsupported
//   illegal_cnt  saturating illegal-entry count (macro builds only)

module alu_ctrl_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sel,
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    output logic       illegal,
    output logic [7:0] illegal_cnt
`else
    output logic       illegal
`endif
);

    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ILL = 4'b1111;

    logic [3:0] dec_sel;
    logic       dec_ill;

    logic       main_valid, main_valid_nxt;
    logic [3:0] main_sel,   main_sel_nxt;
    logic       main_ill,   main_ill_nxt;
    logic       skid_valid, skid_valid_nxt;
    logic [3:0] skid_sel,   skid_sel_nxt;
    logic       skid_ill,   skid_ill_nxt;

    logic       accept;
    logic       drain;

    // Input-side decode; only registered values reach the outputs.
    always_comb begin
        dec_sel = SEL_ILL;
        dec_ill = 1'b1;
        unique case (alu_op)
            2'b00: begin
                dec_sel = SEL_ADD;
                dec_ill = 1'b0;
            end
            2'b01: begin
                dec_sel = SEL_SUB;
                dec_ill = 1'b0;
            end
            2'b10: begin
                unique case (funct3)
                    3'b000: begin
                        dec_sel = funct7_5 ? SEL_SUB : SEL_ADD;
                        dec_ill = 1'b0;
                    end
                    3'b111: begin
                        dec_sel = SEL_AND;
                        dec_ill = 1'b0;
                    end
                    3'b110: begin
                        dec_sel = SEL_OR;
                        dec_ill = 1'b0;
                    end
                    default: begin
                        dec_sel = SEL_ILL;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_sel = SEL_ILL;
                dec_ill = 1'b1;
            end
        endcase
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign sel       = main_sel;
    assign illegal   = main_ill;

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    // Buffer next-state. The skid only fills while main is full and stalled,
    // and in_ready is low whenever the skid is full, so accept and a
    // skid-to-main move never coincide.
    always_comb begin
        main_valid_nxt = main_valid;
        main_sel_nxt   = main_sel;
        main_ill_nxt   = main_ill;
        skid_valid_nxt = skid_valid;
        skid_sel_nxt   = skid_sel;
        skid_ill_nxt   = skid_ill;

        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (drain && skid_valid) begin
            main_valid_nxt = 1'b1;
            main_sel_nxt   = skid_sel;
            main_ill_nxt   = skid_ill;
            skid_valid_nxt = 1'b0;
        end else if (!main_valid || drain) begin
            main_valid_nxt = accept;
            if (accept) begin
                main_sel_nxt = dec_sel;
                main_ill_nxt = dec_ill;
            end
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_sel_nxt   = dec_sel;
            skid_ill_nxt   = dec_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_sel   <= 4'b0000;
            main_ill   <= 1'b0;
            skid_valid <= 1'b0;
            skid_sel   <= 4'b0000;
            skid_ill   <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            main_sel   <= main_sel_nxt;
            main_ill   <= main_ill_nxt;
            skid_valid <= skid_valid_nxt;
            skid_sel   <= skid_sel_nxt;
            skid_ill   <= skid_ill_nxt;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    // Counts entries that actually enter the buffer; a flush cancels the
    // accept on that edge, and flushing never lowers the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= 8'd0;
        end else if (accept && !flush && dec_ill && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = 2'b00;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] sel;
    logic       illegal;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_ctrl_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        .illegal   (illegal),
        .illegal_cnt (illegal_cnt)
`else
        .illegal   (illegal)
`endif
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] esel;
        logic       eill;
    } vec_t;

    vec_t vecs [10] = '{
        '{2'b00, 3'b101, 1'b1, 4'b0010, 1'b0},
        '{2'b01, 3'b000, 1'b0, 4'b0110, 1'b0},
        '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0},
        '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b0},
        '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0},
        '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0},
        '{2'b10, 3'b001, 1'b0, 4'b1111, 1'b1},
        '{2'b10, 3'b101, 1'b1, 4'b1111, 1'b1},
        '{2'b10, 3'b100, 1'b0, 4'b1111, 1'b1},
        '{2'b11, 3'b000, 1'b0, 4'b1111, 1'b1}
    };

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7);
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    initial begin
        int n_out;

        // reset values, and in_valid/flush ignored while rst high
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sel",       32'(sel), 0);
        chk("rst_illegal",   32'(illegal), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        in_valid = 1'b1;
        flush    = 1'b1;
        drive(2'b01, 3'b000, 1'b0);
        step();
        step();
        chk("rst_hold_out_valid", 32'(out_valid), 0);
        chk("rst_hold_sel",       32'(sel), 0);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        step();

        // single R-type sub, one-cycle latency
        drive(2'b10, 3'b000, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("sub_out_valid", 32'(out_valid), 1);
        chk("sub_sel",       32'(sel), 6);
        chk("sub_illegal",   32'(illegal), 0);
        in_valid = 1'b0;
        step();
        chk("sub_drained", 32'(out_valid), 0);

        // full decode table streamed one per cycle
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
            step();
            chk($sformatf("dec%0d_sel", i), 32'(sel), 32'(vecs[i].esel));
            chk($sformatf("dec%0d_ill", i), 32'(illegal), 32'(vecs[i].eill));
            chk($sformatf("dec%0d_vld", i), 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        step();
        chk("dec_drained", 32'(out_valid), 0);

        // backpressure: two accepts fill the buffer, third stalls, FIFO order kept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b00, 3'b000, 1'b0);
        step();
        chk("bp1_in_ready", 32'(in_ready), 1);
        chk("bp1_sel",      32'(sel), 2);
        drive(2'b01, 3'b000, 1'b0);
        step();
        chk("bp2_in_ready", 32'(in_ready), 0);
        chk("bp2_sel",      32'(sel), 2);
        drive(2'b10, 3'b111, 1'b0);
        step();
        chk("bp3_in_ready", 32'(in_ready), 0);
        chk("bp3_sel_stable", 32'(sel), 2);
        chk("bp3_out_valid",  32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        chk("bp4_sel",      32'(sel), 6);
        chk("bp4_in_ready", 32'(in_ready), 1);
        step();
        chk("bp5_sel", 32'(sel), 0);
        chk("bp5_vld", 32'(out_valid), 1);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 32'(out_valid), 0);

        // flush with both entries full dominates a new input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b00, 3'b000, 1'b0);
        step();
        drive(2'b01, 3'b000, 1'b0);
        step();
        chk("fl_full_in_ready", 32'(in_ready), 0);
        drive(2'b10, 3'b110, 1'b0);
        flush = 1'b1;
        step();
        chk("fl_out_valid", 32'(out_valid), 0);
        chk("fl_in_ready",  32'(in_ready), 1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_not_captured", 32'(out_valid), 0);

        // asynchronous reset between edges with both entries full
        in_valid = 1'b1;
        drive(2'b10, 3'b111, 1'b0);
        step();
        drive(2'b10, 3'b110, 1'b0);
        step();
        chk("ar_full_in_ready", 32'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_sel",       32'(sel), 0);
        chk("ar_in_ready",  32'(in_ready), 1);
        step();
        chk("ar_hold_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(2'b01, 3'b000, 1'b0);
        step();
        chk("ar_post_sel", 32'(sel), 6);
        chk("ar_post_vld", 32'(out_valid), 1);
        in_valid = 1'b0;
        step();
        chk("ar_post_empty", 32'(out_valid), 0);

        // sustained throughput for 16 cycles
        n_out = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i % 6].op, vecs[i % 6].f3, vecs[i % 6].f7);
            step();
            if (out_valid) n_out++;
            chk($sformatf("tp%0d_in_ready", i), 32'(in_ready), 1);
            chk($sformatf("tp%0d_sel", i), 32'(sel), 32'(vecs[i % 6].esel));
        end
        in_valid = 1'b0;
        step();
        chk("tp_outputs", n_out, 16);

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        // saturating illegal counter; flush does not decrement
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("cnt_rst", 32'(illegal_cnt), 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(2'b11, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("cnt_5", 32'(illegal_cnt), 5);
        for (int i = 0; i < 295; i++) step();
        in_valid = 1'b0;
        step();
        chk("cnt_sat", 32'(illegal_cnt), 255);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cnt_flush", 32'(illegal_cnt), 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
